// File: rtl/instr_dispatch_unit_pkg.sv
// Shared types, constants and opcode decode for the instruction dispatcher.
package instr_dispatch_unit_pkg;

    typedef struct packed {
        logic [7:0]  opcode;
        logic [7:0]  dest;
        logic [15:0] operand;
    } instr_type;

    localparam instr_type INIT_INSTR = '0;

    localparam logic [7:0] SYNC_OPCODE = 8'hFF;

    // Upper bound on units the shared decode helper can scan.
    localparam int unsigned MAX_UNITS  = 8;
    localparam int unsigned UNIT_IDX_W = 3;

    // Entry i belongs to unit i: weight=0, matrix=1, activation=2.
    localparam logic [2:0][2:0] DEFAULT_UNIT_OPC_BIT = {3'd7, 3'd5, 3'd3};
    localparam logic [2:0][2:0] DEFAULT_DEP_MASK     = {3'b010, 3'b000, 3'b000};

    typedef struct packed {
        logic                  sync;
        logic                  hit;
        logic [UNIT_IDX_W-1:0] idx;
    } decode_t;

    // Returns sync flag plus the winning unit index; the caller expands the index into a
    // one-hot mask of its own width. Highest matching unit wins, sync overrides all.
    function automatic decode_t decode_unit_mask(input logic [7:0]                  opcode,
                                                 input logic [MAX_UNITS-1:0][2:0]   opc_bit,
                                                 input int unsigned                 num_units);
        decode_t d;
        d = '0;
        if (opcode == SYNC_OPCODE) begin
            d.sync = 1'b1;
        end else begin
            for (int unsigned i = 0; i < MAX_UNITS; i++) begin
                if (i < num_units && opcode[opc_bit[i]]) begin
                    d.hit = 1'b1;
                    d.idx = UNIT_IDX_W'(i);
                end
            end
        end
        return d;
    endfunction

endpackage

// File: rtl/instr_dispatch_unit_if.sv
// Host-side and unit-side signal bundle of the instruction dispatcher.
interface instr_dispatch_unit_if #(
    parameter int unsigned NUM_UNITS   = 3,
    parameter int unsigned QUEUE_DEPTH = 4,
    parameter int unsigned STALL_CNT_W = 32
);
    import instr_dispatch_unit_pkg::*;

    logic                               enable;
    instr_type                          instr_i;
    logic                               instr_valid;
    logic                               instr_ready;
    logic                               busy;
    logic [NUM_UNITS-1:0]               unit_busy;
    logic [NUM_UNITS-1:0]               unit_resource_busy;
    instr_type                          unit_instr;
    logic [NUM_UNITS-1:0]               unit_instr_enable;
    logic                               synchronize;
    logic [$clog2(QUEUE_DEPTH+1)-1:0]   queue_level;
    logic [STALL_CNT_W-1:0]             stall_cycles;

    // Driver side: instruction source and execution units.
    modport master (
        output enable, instr_i, instr_valid, unit_busy, unit_resource_busy,
        input  instr_ready, busy, unit_instr, unit_instr_enable, synchronize,
               queue_level, stall_cycles
    );

    // Dispatcher side.
    modport slave (
        input  enable, instr_i, instr_valid, unit_busy, unit_resource_busy,
        output instr_ready, busy, unit_instr, unit_instr_enable, synchronize,
               queue_level, stall_cycles
    );

endinterface

// File: rtl/instr_dispatch_unit_fifo.sv
// Synchronous FIFO with occupancy counter; full/empty come from the level, not pointers.
module instr_fifo #(
    parameter type         data_t = logic [7:0],
    parameter int unsigned Depth  = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        push,
    input  data_t                       push_data,
    input  logic                        pop,
    output data_t                       pop_data,
    output logic [$clog2(Depth+1)-1:0]  level,
    output logic                        full,
    output logic                        empty
);
    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned LvlW = $clog2(Depth+1);

    data_t           mem_q [Depth];
    logic [PtrW-1:0] wr_ptr_q;
    logic [PtrW-1:0] rd_ptr_q;
    logic [LvlW-1:0] level_q;
    logic            do_push;
    logic            do_pop;

    assign full     = (level_q == LvlW'(Depth));
    assign empty    = (level_q == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem_q[rd_ptr_q];
    assign level    = level_q;

    // Pointer and level update; pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            if (do_push && !do_pop)      level_q <= level_q + LvlW'(1);
            else if (!do_push && do_pop) level_q <= level_q - LvlW'(1);
        end
    end

    // Storage array, no reset needed since reads are qualified by the level.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/instr_dispatch_unit.sv
// Queues instructions, decodes the target unit and issues once target and dependencies idle.
module instr_dispatch_unit
    import instr_dispatch_unit_pkg::*;
#(
    parameter int unsigned                          NUM_UNITS    = 3,
    parameter int unsigned                          QUEUE_DEPTH  = 4,
    parameter logic [NUM_UNITS-1:0][2:0]            UNIT_OPC_BIT = DEFAULT_UNIT_OPC_BIT,
    parameter logic [NUM_UNITS-1:0][NUM_UNITS-1:0]  DEP_MASK     = DEFAULT_DEP_MASK,
    parameter int unsigned                          STALL_CNT_W  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    instr_dispatch_unit_if.slave  bus
);
    localparam int unsigned LvlW = $clog2(QUEUE_DEPTH+1);

    instr_type                     fifo_data;
    logic [LvlW-1:0]               fifo_level;
    logic                          fifo_full;
    logic                          fifo_empty;
    logic                          fifo_push;

    logic                          stage_valid_q;
    instr_type                     stage_instr_q;
    logic [NUM_UNITS-1:0]          stage_mask_q;
    logic [NUM_UNITS-1:0]          stage_check_q;
    logic                          stage_sync_q;
    logic [STALL_CNT_W-1:0]        stall_q;

    logic                          blocked;
    logic                          retire;
    logic                          load;

    logic [MAX_UNITS-1:0][2:0]     opc_bit_ext;
    decode_t                       dec;
    logic [NUM_UNITS-1:0]          dec_mask;
    logic [NUM_UNITS-1:0]          dec_check;

    assign bus.instr_ready = !fifo_full && !rst;
    assign fifo_push       = bus.instr_valid && bus.instr_ready;

    assign blocked = stage_sync_q ? |bus.unit_resource_busy
                                  : |(bus.unit_busy & stage_check_q);
    assign retire  = stage_valid_q && bus.enable && !blocked && !rst;
    assign load    = bus.enable && !fifo_empty && (!stage_valid_q || retire) && !rst;

    instr_fifo #(
        .data_t (instr_type),
        .Depth  (QUEUE_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (bus.instr_i),
        .pop       (load),
        .pop_data  (fifo_data),
        .level     (fifo_level),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Decode the FIFO head into unit mask plus dependency-extended check mask.
    always_comb begin
        opc_bit_ext = '0;
        for (int unsigned i = 0; i < NUM_UNITS; i++) opc_bit_ext[i] = UNIT_OPC_BIT[i];
        dec       = decode_unit_mask(fifo_data.opcode, opc_bit_ext, NUM_UNITS);
        dec_mask  = dec.hit ? (NUM_UNITS'(1) << dec.idx) : '0;
        dec_check = dec_mask;
        for (int unsigned i = 0; i < NUM_UNITS; i++) begin
            if (dec_mask[i]) dec_check = dec_check | DEP_MASK[i];
        end
    end

    // Dispatch stage: load from the FIFO when empty or retiring, otherwise hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            stage_valid_q <= 1'b0;
            stage_instr_q <= INIT_INSTR;
            stage_mask_q  <= '0;
            stage_check_q <= '0;
            stage_sync_q  <= 1'b0;
        end else if (load) begin
            stage_valid_q <= 1'b1;
            stage_instr_q <= fifo_data;
            stage_mask_q  <= dec_mask;
            stage_check_q <= dec_check;
            stage_sync_q  <= dec.sync;
        end else if (retire) begin
            stage_valid_q <= 1'b0;
        end
    end

    // Saturating count of enabled cycles spent blocked with an instruction staged.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
        end else if (stage_valid_q && bus.enable && blocked && (stall_q != '1)) begin
            stall_q <= stall_q + STALL_CNT_W'(1);
        end
    end

    assign bus.unit_instr        = stage_instr_q;
    assign bus.unit_instr_enable = retire ? stage_mask_q : '0;
    assign bus.synchronize       = retire && stage_sync_q;
    assign bus.queue_level       = fifo_level;
    assign bus.stall_cycles      = stall_q;
    assign bus.busy              = !rst && (stage_valid_q || (fifo_level != '0));

endmodule

// File: tb/tb_instr_dispatch_unit.sv
// Directed bench: queue-level reference model checked every cycle plus hand-pinned values.
module tb_instr_dispatch_unit;
    import instr_dispatch_unit_pkg::*;

    localparam int unsigned NU = 3;
    localparam int unsigned QD = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    instr_dispatch_unit_if #(.NUM_UNITS(NU), .QUEUE_DEPTH(QD), .STALL_CNT_W(32)) bus ();

    instr_dispatch_unit #(
        .NUM_UNITS   (NU),
        .QUEUE_DEPTH (QD),
        .STALL_CNT_W (32)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          n_vec = 0;
    int          n_err = 0;
    bit          cmp_on = 1'b0;
    int unsigned seq = 0;

    // Model: every accepted, unretired instruction in arrival order; head is staged or not.
    instr_type   mq[$];
    bit          m_staged = 1'b0;
    int unsigned m_stall = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h, want %0h", nm, $time, act, exp);
        end
    endtask

    // Unit rules: opcode FF syncs; else bit7 activation (waits on matrix), bit5 matrix, bit3 weight.
    function automatic void m_decode(input logic [7:0] op, output logic [2:0] mask,
                                     output logic [2:0] need, output logic sy);
        mask = 3'b000; need = 3'b000; sy = 1'b0;
        if (op == 8'hFF)  sy = 1'b1;
        else if (op[7]) begin mask = 3'b100; need = 3'b110; end
        else if (op[5]) begin mask = 3'b010; need = 3'b010; end
        else if (op[3]) begin mask = 3'b001; need = 3'b001; end
    endfunction

    function automatic int m_level();
        return mq.size() - (m_staged ? 1 : 0);
    endfunction

    function automatic void m_outputs(output logic [2:0] strb, output logic sy, output logic blk);
        logic [2:0] mask;
        logic [2:0] need;
        logic       s;
        strb = 3'b000; sy = 1'b0; blk = 1'b0;
        if (m_staged) begin
            m_decode(mq[0].opcode, mask, need, s);
            blk = s ? (|bus.unit_resource_busy) : (|(bus.unit_busy & need));
            if (bus.enable && !rst && !blk) begin
                strb = mask;
                sy   = s;
            end
        end
    endfunction

    always @(posedge clk) begin
        logic [2:0] strb;
        logic       sy;
        logic       blk;
        bit         ret;
        bit         ld;
        bit         psh;
        if (rst) begin
            mq.delete();
            m_staged = 1'b0;
            m_stall  = 0;
        end else begin
            m_outputs(strb, sy, blk);
            ret = m_staged && bus.enable && !blk;
            ld  = bus.enable && (m_level() > 0) && (!m_staged || ret);
            psh = bus.instr_valid && (m_level() < QD);
            if (m_staged && bus.enable && blk && m_stall != 32'hFFFF_FFFF) m_stall++;
            if (ret) void'(mq.pop_front());
            m_staged = ld || (m_staged && !ret);
            if (psh) mq.push_back(bus.instr_i);
        end
    end

    always @(negedge clk) begin
        logic [2:0] strb;
        logic       sy;
        logic       blk;
        if (cmp_on) begin
            m_outputs(strb, sy, blk);
            chk("instr_ready", 64'(bus.instr_ready), 64'(!rst && (m_level() < QD)));
            chk("busy", 64'(bus.busy), 64'(!rst && (mq.size() != 0)));
            chk("unit_instr_enable", 64'(bus.unit_instr_enable), 64'(strb));
            chk("synchronize", 64'(bus.synchronize), 64'(sy));
            chk("queue_level", 64'(bus.queue_level), 64'(m_level()));
            chk("stall_cycles", 64'(bus.stall_cycles), 64'(m_stall));
            if (m_staged) chk("unit_instr", 64'(bus.unit_instr), 64'(mq[0]));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one instruction until a handshake edge; returns 1 time unit after that edge.
    task automatic push(input logic [7:0] op);
        bit done;
        done = 1'b0;
        seq++;
        bus.instr_i.opcode  = op;
        bus.instr_i.dest    = ~op;
        bus.instr_i.operand = 16'(seq);
        bus.instr_valid     = 1'b1;
        for (int k = 0; k < 50 && !done; k++) begin
            @(negedge clk);
            done = bus.instr_ready;
            @(posedge clk);
            #1;
        end
        bus.instr_valid = 1'b0;
        if (!done) begin
            n_vec++;
            n_err++;
            $display("FAIL push_timeout op=%0h: got no ready, want ready within 50 cycles", op);
        end
    endtask

    initial begin
        bus.enable             = 1'b1;
        bus.instr_i            = INIT_INSTR;
        bus.instr_valid        = 1'b0;
        bus.unit_busy          = 3'b000;
        bus.unit_resource_busy = 3'b000;

        // Reset state
        tick();
        tick();
        cmp_on = 1'b1;
        #1;
        chk("rst_ready_low", 64'(bus.instr_ready), 64'd0);
        chk("rst_busy_low", 64'(bus.busy), 64'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_level", 64'(bus.queue_level), 64'd0);
        chk("post_rst_stall", 64'(bus.stall_cycles), 64'd0);
        chk("post_rst_unit_instr", 64'(bus.unit_instr), 64'(INIT_INSTR));
        chk("post_rst_ready", 64'(bus.instr_ready), 64'd1);

        // 1: single weight instruction, strobe in the cycle after the load edge
        push(8'h08);
        #1 chk("t1_no_early_strobe", 64'(bus.unit_instr_enable), 64'd0);
        tick();
        #1 chk("t1_weight_strobe", 64'(bus.unit_instr_enable), 64'(3'b001));
        tick();
        #1 chk("t1_strobe_gone", 64'(bus.unit_instr_enable), 64'd0);
        chk("t1_idle", 64'(bus.busy), 64'd0);

        // 2: fill the queue behind a blocked stage, then drain in order
        bus.unit_busy = 3'b111;
        push(8'h08);
        push(8'h20);
        push(8'h80);
        push(8'h00);
        push(8'h28);
        #1 chk("t2_ready_low_full", 64'(bus.instr_ready), 64'd0);
        chk("t2_level_full", 64'(bus.queue_level), 64'd4);
        chk("t2_stall_3", 64'(bus.stall_cycles), 64'd3);
        bus.unit_busy = 3'b000;
        #1 chk("t2_issue_weight", 64'(bus.unit_instr_enable), 64'(3'b001));
        chk("t2_no_passthrough", 64'(bus.instr_ready), 64'd0);
        tick();
        #1 chk("t2_issue_matrix", 64'(bus.unit_instr_enable), 64'(3'b010));
        tick();
        #1 chk("t2_issue_act", 64'(bus.unit_instr_enable), 64'(3'b100));
        tick();
        #1 chk("t2_nop_no_strobe", 64'(bus.unit_instr_enable), 64'd0);
        chk("t2_nop_staged", 64'(bus.busy), 64'd1);
        tick();
        #1 chk("t2_issue_matrix_hi", 64'(bus.unit_instr_enable), 64'(3'b010));
        tick();
        #1 chk("t2_drained", 64'(bus.busy), 64'd0);

        // 3: activation waits on matrix busy
        bus.unit_busy = 3'b010;
        push(8'h80);
        tick();
        #1 chk("t3_blocked", 64'(bus.unit_instr_enable), 64'd0);
        tick();
        tick();
        bus.unit_busy = 3'b000;
        #1 chk("t3_issue_act", 64'(bus.unit_instr_enable), 64'(3'b100));
        tick();

        // 4: sync waits for resource busy, then a single strobe
        bus.unit_resource_busy = 3'b001;
        push(8'hFF);
        tick();
        #1 chk("t4_sync_held", 64'(bus.synchronize), 64'd0);
        tick();
        tick();
        bus.unit_resource_busy = 3'b000;
        #1 chk("t4_sync_fire", 64'(bus.synchronize), 64'd1);
        chk("t4_sync_no_units", 64'(bus.unit_instr_enable), 64'd0);
        tick();
        #1 chk("t4_sync_once", 64'(bus.synchronize), 64'd0);

        // 5: enable low freezes stage, queue and stall counter
        bus.unit_busy = 3'b111;
        push(8'h08);
        push(8'h20);
        push(8'h80);
        bus.enable = 1'b0;
        tick();
        tick();
        tick();
        bus.unit_busy = 3'b000;
        #1 chk("t5_level_held", 64'(bus.queue_level), 64'd2);
        chk("t5_no_strobe", 64'(bus.unit_instr_enable), 64'd0);
        bus.enable = 1'b1;
        #1 chk("t5_resume_weight", 64'(bus.unit_instr_enable), 64'(3'b001));
        tick();
        tick();
        tick();

        // 6: reset mid-operation discards everything
        bus.unit_busy = 3'b111;
        push(8'h08);
        push(8'h20);
        push(8'h80);
        push(8'h28);
        tick();
        rst = 1'b1;
        bus.unit_busy = 3'b000;
        #1 chk("t6_no_strobe_in_rst", 64'(bus.unit_instr_enable), 64'd0);
        chk("t6_busy_low_in_rst", 64'(bus.busy), 64'd0);
        tick();
        rst = 1'b0;
        #1 chk("t6_level_cleared", 64'(bus.queue_level), 64'd0);
        chk("t6_stall_cleared", 64'(bus.stall_cycles), 64'd0);
        chk("t6_busy_cleared", 64'(bus.busy), 64'd0);
        chk("t6_ready_back", 64'(bus.instr_ready), 64'd1);
        push(8'h20);
        tick();
        #1 chk("t6_after_rst_issue", 64'(bus.unit_instr_enable), 64'(3'b010));
        tick();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
